sail_print_arbiter: RTL and testbench
=====================================

Name: sail_print_arbiter

Overview:
- Shares one synthesizable Sail stdout byte stream between NUM_REQ requesters. Each requester issues print or print_endline calls as byte streams.
- Grants whole messages round-robin and never interleaves bytes of two messages.
- Appends "\n" for endline messages and pulses a per-requester done, which is the unit return of the print call.
- Sits between the Sail-generated print call sites and the single console or trace sink.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- OWNER_W, $clog2(NUM_REQ), width of owner index (derived; not user-set).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of the message.
- req_endline  input  NUM_REQ  sampled with last byte; 1 = append newline.
- req_ready  output  NUM_REQ  byte accepted when valid & ready.
- out_valid  output  1  stdout byte valid.
- out_data  output  8  stdout byte.
- out_ready  input  1  sink accepts byte.
- out_owner  output  OWNER_W  index of current grant holder.
- busy  output  1  state != IDLE.
- msg_done  output  NUM_REQ  one-cycle pulse when requester's message (incl. newline) fully emitted.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, rr_ptr=0, owner=0, out_valid=0, out_data=0, req_ready=0, msg_done=0, busy=0.
- States: IDLE, STREAM, NEWLINE.
- IDLE:
  - out_valid=0, req_ready=0.
  - If any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Register the pick as owner and go to STREAM next cycle. Arbitration costs exactly one bubble cycle per message.
- STREAM, combinational pass-through from owner only:
  - out_valid = req_valid[owner] && req_data[owner] != 8'h00.
  - out_data = req_data[owner].
  - req_ready[owner] = out_ready, or 1 if the byte is 8'h00. All other req_ready=0.
- NUL bytes are consumed and dropped; this allows empty messages. For example, print_endline("") is sent as a single 8'h00 with last=1, endline=1.
- On owner handshake with req_last=1:
  - If req_endline=1, go to NEWLINE.
  - Otherwise, pulse msg_done[owner] next cycle, set rr_ptr = (owner+1) mod NUM_REQ, and go to IDLE.
- NEWLINE:
  - out_valid=1, out_data=8'h0A, req_ready all 0.
  - On out_ready, pulse msg_done[owner], advance rr_ptr, go to IDLE.
- No preemption: if the owner deasserts req_valid mid-message, hold the grant with out_valid=0 indefinitely.
- Non-owner requesters see req_ready=0 and must hold their bytes stable (valid/ready rules).
- out_valid, once asserted, stays high with stable data until out_ready (inherited from requester stability in STREAM; guaranteed in NEWLINE).
- out_owner = owner register in all states; busy = (state != IDLE).
- Reset mid-message: the partial message is abandoned, no msg_done is pulsed, and the requester must restart the whole message.
- Simultaneous requests: the round-robin pointer guarantees each waiting requester is granted within NUM_REQ messages.
- rr_ptr wraps NUM_REQ-1 -> 0.

Decomposition:
- Package sail_print_pkg holds:
  - typedef enum logic [1:0] {SP_IDLE, SP_STREAM, SP_NEWLINE} sail_print_state.
  - Constants SAIL_NEWLINE = 8'h0A and SAIL_NUL = 8'h00.
- One sub-module, sail_rr_pick (combinational round-robin picker):
  - Inputs: request vector, pointer.
  - Outputs: grant index, any_req.
  - Reusable by other Sail resource arbiters.

Test Plan:
- Single message: req 0 sends "hi" (0x68, 0x69 last, endline=0), out_ready=1 -> out bytes 0x68, 0x69; msg_done[0] pulses one cycle after the last handshake; busy returns to 0.
- Endline: req 2 sends "ok" with endline=1 -> out stream 0x6F, 0x6B, 0x0A; msg_done[2] pulses only after 0x0A is accepted.
- Contention: reqs 0, 1, 3 all valid from reset, each sending a 1-byte message -> grant order 0, 1, 3. A repeat request from 0 is then served after 3. No interleaving of bytes.
- Backpressure: out_ready toggles 1, 0, 0, 1 during a 3-byte message -> out_data is held stable while stalled, no bytes are lost or duplicated, req_ready mirrors out_ready.
- Empty endline: req 1 sends a single 0x00 with last=1, endline=1 -> the only output byte is 0x0A; msg_done[1] pulses.
- Reset mid-message: assert reset after 1 of 3 bytes -> next cycle out_valid=0, msg_done=0, rr_ptr=0. The resent message is emitted in full from byte 0.

Source files
------------

// File: rtl/sail_print_pkg.sv
// Shared types and constants for the Sail stdout print arbiter and its helpers.
package sail_print_pkg;

    typedef enum logic [1:0] {
        SP_IDLE    = 2'd0,
        SP_STREAM  = 2'd1,
        SP_NEWLINE = 2'd2
    } sail_print_state;

    localparam logic [7:0] SAIL_NEWLINE = 8'h0A;
    localparam logic [7:0] SAIL_NUL     = 8'h00;

    // NUL bytes carry no text; they only let a caller send an empty message.
    function automatic logic sail_is_nul(input logic [7:0] b);
        return b == SAIL_NUL;
    endfunction

endpackage

// File: rtl/sail_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module sail_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int OWNER_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] grant,
    output logic               any_req
);

    logic [OWNER_W-1:0] idx [NUM_REQ];

    // idx[gi] is the requester examined gi steps after ptr.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_idx
            logic [OWNER_W:0] sum;
            assign sum     = {1'b0, ptr} + (OWNER_W+1)'(gi);
            assign idx[gi] = (sum >= (OWNER_W+1)'(NUM_REQ)) ?
                             OWNER_W'(sum - (OWNER_W+1)'(NUM_REQ)) : OWNER_W'(sum);
        end
    endgenerate

    always_comb begin
        grant   = '0;
        any_req = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[idx[k]]) begin
                grant = idx[k];
            end
        end
    end

endmodule

// File: rtl/sail_print_arbiter.sv
// Round-robin arbiter sharing one Sail stdout byte stream between NUM_REQ print call sites,
// granting whole messages and appending a newline for print_endline.
module sail_print_arbiter
    import sail_print_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int OWNER_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ-1:0]   req_endline,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic [OWNER_W-1:0]   out_owner,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   msg_done
);

    localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_REQ - 1);

    sail_print_state     state_q, state_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  done_q, done_d;

    logic [7:0]          req_bytes [NUM_REQ];
    logic [OWNER_W-1:0]  pick_grant;
    logic                pick_any;
    logic [7:0]          owner_byte;
    logic                owner_valid;
    logic                owner_last;
    logic                owner_endline;
    logic                owner_nul;
    logic                owner_take;
    logic [OWNER_W-1:0]  next_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data[gi*8 +: 8];
        end
    endgenerate

    sail_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (pick_grant),
        .any_req (pick_any)
    );

    assign owner_byte    = req_bytes[owner_q];
    assign owner_valid   = req_valid[owner_q];
    assign owner_last    = req_last[owner_q];
    assign owner_endline = req_endline[owner_q];
    assign owner_nul     = sail_is_nul(owner_byte);
    // NUL bytes are swallowed without waiting for the sink.
    assign owner_take    = out_ready || owner_nul;
    assign next_ptr      = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        done_d    = '0;
        out_valid = 1'b0;
        out_data  = SAIL_NUL;
        req_ready = '0;
        case (state_q)
            SP_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_grant;
                    state_d = SP_STREAM;
                end
            end
            SP_STREAM: begin
                out_valid          = owner_valid && !owner_nul;
                out_data           = owner_byte;
                req_ready[owner_q] = owner_take;
                if (owner_valid && owner_take && owner_last) begin
                    if (owner_endline) begin
                        state_d = SP_NEWLINE;
                    end else begin
                        done_d[owner_q] = 1'b1;
                        rr_ptr_d        = next_ptr;
                        state_d         = SP_IDLE;
                    end
                end
            end
            SP_NEWLINE: begin
                out_valid = 1'b1;
                out_data  = SAIL_NEWLINE;
                if (out_ready) begin
                    done_d[owner_q] = 1'b1;
                    rr_ptr_d        = next_ptr;
                    state_d         = SP_IDLE;
                end
            end
            default: begin
                state_d = SP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SP_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            done_q   <= done_d;
        end
    end

    assign msg_done  = done_q;
    assign out_owner = owner_q;
    assign busy      = (state_q != SP_IDLE);

endmodule

// File: tb/tb_sail_print_arbiter.sv
// Self-checking bench for sail_print_arbiter: queued messages per requester, a message-level
// round-robin model producing the expected stdout stream, and randomized backpressure.
module tb_sail_print_arbiter;

    localparam int NUM_REQ = 4;
    localparam int OWNER_W = $clog2(NUM_REQ);

    typedef struct {
        logic [7:0] d;
        bit         last;
        bit         endl;
    } beat_t;

    typedef struct {
        logic [7:0] d;
        int         owner;
        bit         fin;
        bit         nl;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_endline;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [7:0]           out_data;
    logic                 out_ready;
    logic [OWNER_W-1:0]   out_owner;
    logic                 busy;
    logic [NUM_REQ-1:0]   msg_done;

    int    n_vec = 0;
    int    n_err = 0;
    int    model_ptr = 0;
    int    first_hs_cycle;
    beat_t src_q [NUM_REQ][$];
    exp_t  exp_q [$];

    always #5 clk = ~clk;

    sail_print_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_endline (req_endline),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_owner   (out_owner),
        .busy        (busy),
        .msg_done    (msg_done)
    );

    // Byte i of the message sits in bytes[8i+7:8i].
    task automatic add_msg(input int r, input logic [63:0] bytes, input int len, input bit endl);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d    = bytes[i*8 +: 8];
            b.last = (i == len - 1);
            b.endl = endl;
            src_q[r].push_back(b);
        end
    endtask

    // Message-level model: whole messages leave in round-robin order over requesters that
    // still have queued messages; NULs vanish and endline messages gain a trailing 0x0A.
    task automatic build_expected();
        int    rd [NUM_REQ];
        int    sel;
        bit    found;
        beat_t b;
        exp_t  e;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 0;
        forever begin
            found = 0;
            sel   = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && rd[(model_ptr + k) % NUM_REQ] < src_q[(model_ptr + k) % NUM_REQ].size()) begin
                    found = 1;
                    sel   = (model_ptr + k) % NUM_REQ;
                end
            end
            if (!found) break;
            forever begin
                b = src_q[sel][rd[sel]];
                rd[sel]++;
                if (b.d != 8'h00) begin
                    e.d = b.d; e.owner = sel; e.fin = 0; e.nl = 0;
                    exp_q.push_back(e);
                end
                if (b.last) begin
                    if (b.endl) begin
                        e.d = 8'h0A; e.owner = sel; e.fin = 1; e.nl = 1;
                        exp_q.push_back(e);
                    end else begin
                        exp_q[exp_q.size() - 1].fin = 1;
                    end
                    break;
                end
            end
            model_ptr = (sel + 1) % NUM_REQ;
        end
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        req_endline = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
    endtask

    // mode 0: sink always ready; 1: random ready; 2: ready pattern 1,0,0,1 from the first STREAM cycle.
    task automatic run(input int mode, input int max_cycles, input int stop_after);
        int                 cyc = 0;
        int                 hs = 0;
        int                 done_next = -1;
        int                 done_cur;
        bit                 pending = 1;
        logic               stall_prev = 1'b0;
        logic [7:0]         data_prev = 8'h00;
        logic [NUM_REQ-1:0] exp_done;
        exp_t               e;
        first_hs_cycle = -1;
        while (pending && cyc < max_cycles && !(stop_after > 0 && hs >= stop_after)) begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (src_q[r].size() > 0) begin
                    req_valid[r]       = 1'b1;
                    req_data[r*8 +: 8] = src_q[r][0].d;
                    req_last[r]        = src_q[r][0].last;
                    req_endline[r]     = src_q[r][0].endl;
                end else begin
                    req_valid[r]       = 1'b0;
                    req_data[r*8 +: 8] = 8'h00;
                    req_last[r]        = 1'b0;
                    req_endline[r]     = 1'b0;
                end
            end
            case (mode)
                1:       out_ready = ($urandom % 4) != 0;
                2:       out_ready = !(cyc == 2 || cyc == 3);
                default: out_ready = 1'b1;
            endcase
            #1;
            done_cur  = done_next;
            done_next = -1;
            exp_done  = '0;
            if (done_cur >= 0) exp_done[done_cur] = 1'b1;
            n_vec++;
            if (msg_done !== exp_done) begin
                n_err++;
                $display("FAIL msg_done cyc=%0d got=%b want=%b", cyc, msg_done, exp_done);
            end
            n_vec++;
            if ($countones(req_ready) > 1 || (!busy && (req_ready !== '0 || out_valid !== 1'b0))) begin
                n_err++;
                $display("FAIL grant_excl cyc=%0d got ready=%b valid=%b busy=%b want onehot/idle-quiet",
                         cyc, req_ready, out_valid, busy);
            end
            if (stall_prev) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== data_prev) begin
                    n_err++;
                    $display("FAIL hold cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                             cyc, out_valid, out_data, data_prev);
                end
            end
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
                n_vec++;
                if (exp_q[0].nl) begin
                    if (req_ready !== '0) begin
                        n_err++;
                        $display("FAIL ready_nl cyc=%0d got=%b want=0", cyc, req_ready);
                    end
                end else if (req_ready[out_owner] !== out_ready) begin
                    n_err++;
                    $display("FAIL ready_mirror cyc=%0d got=%b want=%b", cyc, req_ready[out_owner], out_ready);
                end
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (req_valid[r] && req_ready[r] === 1'b1 && src_q[r].size() > 0) begin
                    void'(src_q[r].pop_front());
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                hs++;
                if (first_hs_cycle < 0) first_hs_cycle = cyc;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_byte cyc=%0d got=%h owner=%0d want none", cyc, out_data, out_owner);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || int'(out_owner) != e.owner) begin
                        n_err++;
                        $display("FAIL out_byte cyc=%0d got=%h/%0d want=%h/%0d", cyc, out_data, out_owner, e.d, e.owner);
                    end
                    if (e.fin) begin
                        done_next = e.owner;
                        $display("msg req %0d complete at t=%0t", e.owner, $time);
                    end
                end
            end
            stall_prev = (out_valid === 1'b1) && !out_ready;
            data_prev  = out_data;
            cyc++;
            pending = (exp_q.size() > 0) || (done_next >= 0);
            for (int r = 0; r < NUM_REQ; r++) if (src_q[r].size() > 0) pending = 1;
        end
        if (stop_after == 0) begin
            n_vec++;
            if (pending) begin
                n_err++;
                $display("FAIL timeout got %0d bytes outstanding want 0", exp_q.size());
            end
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL busy_end got=%b want=0", busy);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        req_data  = {NUM_REQ{8'h55}};
        req_last  = '1;
        req_endline = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || req_ready !== '0 || msg_done !== '0 ||
            busy !== 1'b0 || out_owner !== '0) begin
            n_err++;
            $display("FAIL reset got v=%b d=%h rdy=%b done=%b busy=%b own=%0d want all 0",
                     out_valid, out_data, req_ready, msg_done, busy, out_owner);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic test_single();
        add_msg(0, 64'h6968, 2, 0);
        build_expected();
        run(0, 50, 0);
        n_vec++;
        if (first_hs_cycle != 1) begin
            n_err++;
            $display("FAIL bubble got first byte cycle %0d want 1", first_hs_cycle);
        end
    endtask

    task automatic test_endline();
        add_msg(2, 64'h6B6F, 2, 1);
        build_expected();
        run(0, 50, 0);
    endtask

    task automatic test_contention();
        do_reset();
        add_msg(0, 64'h41, 1, 0);
        add_msg(1, 64'h42, 1, 0);
        add_msg(3, 64'h43, 1, 0);
        add_msg(0, 64'h44, 1, 0);
        build_expected();
        run(0, 100, 0);
    endtask

    task automatic test_backpressure();
        add_msg(1, 64'h636261, 3, 0);
        build_expected();
        run(2, 50, 0);
    endtask

    task automatic test_empty_endline();
        add_msg(1, 64'h00, 1, 1);
        build_expected();
        run(0, 50, 0);
    endtask

    task automatic test_reset_mid();
        add_msg(3, 64'h333231, 3, 0);
        build_expected();
        run(0, 50, 1);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || msg_done !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got v=%b done=%b busy=%b want 0/0/0", out_valid, msg_done, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int r = 0; r < NUM_REQ; r++) src_q[r].delete();
        model_ptr = 0;
        add_msg(3, 64'h333231, 3, 0);
        add_msg(1, 64'h5A, 1, 0);
        build_expected();
        run(0, 100, 0);
    endtask

    task automatic test_random();
        logic [63:0] bytes;
        int          len;
        int          nmsg;
        for (int round = 0; round < 8; round++) begin
            nmsg = 0;
            for (int r = 0; r < NUM_REQ; r++) begin
                for (int m = 0; m < int'($urandom_range(0, 2)); m++) begin
                    nmsg++;
                    if ($urandom % 6 == 0) begin
                        add_msg(r, 64'h00, 1, 1);
                    end else begin
                        len   = $urandom_range(1, 5);
                        bytes = '0;
                        for (int i = 0; i < len; i++) begin
                            if (i != len - 1 && $urandom % 5 == 0) bytes[i*8 +: 8] = 8'h00;
                            else bytes[i*8 +: 8] = 8'($urandom_range(32, 126));
                        end
                        add_msg(r, bytes, len, 1'($urandom % 2));
                    end
                end
            end
            if (nmsg == 0) add_msg(round % NUM_REQ, 64'h41, 1, 1);
            build_expected();
            run(1, 3000, 0);
        end
    endtask

    initial begin
        idle_inputs();
        reset     = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_endline();
        test_contention();
        test_backpressure();
        test_empty_endline();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
